// File: rtl/buffer_mem_arbiter.sv
// buffer_mem_arbiter: shares one single-port buffer SRAM between the
// matrix_mult core and a host loader/readback port.
//
// The core has priority and may lock the port for a burst. The host gets
// idle cycles. Each issued read is tagged with its issuer, so the returning
// data is steered back to the requester that issued it.
//
// Optional feature macro: STARVE_GUARD_EN
//   When it is defined, a host wait counter and a one-cycle FORCE_HOST state
//   guarantee the host a grant every MAX_WAIT+1 cycles.
//   When it is undefined, the core has strict priority and core_stall_o is 0.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   core_cenb_i/wenb_i/addr_i/d_i core access (active-low enables)
//   core_lock_i                  core holds the port while high
//   core_q_o                     core read data (pass-through of mem_q_i)
//   core_stall_o                 core request pending but not issued
//   host_req_i/we_i/addr_i/d_i   host access request
//   host_gnt_o                   host access issued this cycle
//   host_rvalid_o/rdata_o        host read return, RD_LAT after grant
//   mem_*                        SRAM port (combinational from the selected issuer)
//   owner_o                      issuer of the previous cycle (0 core, 1 host)
module buffer_mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SIZE       = 256,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    core_cenb_i,
    input  logic                    core_wenb_i,
    input  logic [$clog2(SIZE)-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0]   core_d_i,
    input  logic                    core_lock_i,
    output logic [DATA_WIDTH-1:0]   core_q_o,
    output logic                    core_stall_o,
    input  logic                    host_req_i,
    input  logic                    host_we_i,
    input  logic [$clog2(SIZE)-1:0] host_addr_i,
    input  logic [DATA_WIDTH-1:0]   host_d_i,
    output logic                    host_gnt_o,
    output logic                    host_rvalid_o,
    output logic [DATA_WIDTH-1:0]   host_rdata_o,
    output logic                    mem_cenb_o,
    output logic                    mem_wenb_o,
    output logic [$clog2(SIZE)-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_d_o,
    input  logic [DATA_WIDTH-1:0]   mem_q_i,
    output logic                    owner_o
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CORE_LOCK = 2'd1;
`ifdef STARVE_GUARD_EN
    localparam logic [1:0]  ST_FORCE_HOST = 2'd2;
    localparam int unsigned CW            = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_q, wait_d;
`endif

    // Elaboration-time parameter range check
    if (RD_LAT < 1 || RD_LAT > 4 || MAX_WAIT < 1) begin : g_bad_param
        $error("buffer_mem_arbiter: RD_LAT must be 1..4 and MAX_WAIT >= 1");
    end

    logic [1:0]        state_q, state_d;
    logic              core_req;
    logic              sel_core;
    logic              sel_host;
    logic              issue_rd;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_own_q, tag_own_d;
    logic              owner_q;

    assign core_req = ~core_cenb_i;

    // Arbitration, next state and host wait counter
    always_comb begin
        state_d  = state_q;
        sel_core = 1'b0;
        sel_host = 1'b0;
`ifdef STARVE_GUARD_EN
        wait_d   = '0;
`endif
        if (!rst_i) begin
            case (state_q)
                ST_CORE_LOCK: begin
                    sel_core = core_req;
                    if (!core_lock_i) begin
                        // Lock released: this cycle already arbitrates as IDLE
                        sel_host = host_req_i & ~core_req;
                        state_d  = ST_IDLE;
                    end
                end
`ifdef STARVE_GUARD_EN
                ST_FORCE_HOST: begin
                    sel_host = host_req_i;
                    sel_core = core_req & ~host_req_i;
                    state_d  = core_lock_i ? ST_CORE_LOCK : ST_IDLE;
                end
`endif
                default: begin
                    sel_core = core_req;
                    sel_host = host_req_i & ~core_req;
                    state_d  = (core_req && core_lock_i) ? ST_CORE_LOCK : ST_IDLE;
                end
            endcase
`ifdef STARVE_GUARD_EN
            // Count waiting cycles; the cycle reaching MAX_WAIT arms FORCE_HOST
            if (host_req_i && !sel_host) begin
                wait_d = (wait_q == CW'(MAX_WAIT)) ? wait_q : wait_q + CW'(1);
                if (wait_d == CW'(MAX_WAIT)) begin
                    state_d = ST_FORCE_HOST;
                end
            end
`endif
        end
    end

    // Memory port mux
    always_comb begin
        mem_cenb_o = ~(sel_core | sel_host);
        mem_wenb_o = 1'b1;
        mem_addr_o = '0;
        mem_d_o    = '0;
        if (sel_host) begin
            mem_wenb_o = ~host_we_i;
            mem_addr_o = host_addr_i;
            mem_d_o    = host_d_i;
        end else if (sel_core) begin
            mem_wenb_o = core_wenb_i;
            mem_addr_o = core_addr_i;
            mem_d_o    = core_d_i;
        end
    end

    assign host_gnt_o = sel_host;
    assign issue_rd   = (sel_host & ~host_we_i) | (sel_core & core_wenb_i);

`ifdef STARVE_GUARD_EN
    assign core_stall_o = core_req & ~sel_core & ~rst_i;
`else
    assign core_stall_o = 1'b0;
`endif

    // Read tag shift register: stage 0 takes this cycle's read, oldest stage falls off
    always_comb begin
        tag_vld_d = RD_LAT'({tag_vld_q, issue_rd});
        tag_own_d = RD_LAT'({tag_own_q, sel_host});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            tag_vld_q <= '0;
            tag_own_q <= '0;
            owner_q   <= 1'b0;
`ifdef STARVE_GUARD_EN
            wait_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tag_vld_q <= tag_vld_d;
            tag_own_q <= tag_own_d;
            owner_q   <= sel_host;
`ifdef STARVE_GUARD_EN
            wait_q    <= wait_d;
`endif
        end
    end

    // Read returns; reset in flight suppresses any pending host return
    assign host_rvalid_o = tag_vld_q[RD_LAT-1] & tag_own_q[RD_LAT-1] & ~rst_i;
    assign host_rdata_o  = host_rvalid_o ? mem_q_i : '0;
    assign core_q_o      = mem_q_i;
    assign owner_o       = owner_q;

endmodule
